// File: rtl/mouse_tracker_if.sv
// Byte stream from the PS/2 controller into the mouse packet decoder.
interface mouse_tracker_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder: aligns 3/4-byte packets, scales the deltas and
// clamps the cursor into the configured screen window.
module mouse_tracker #(
   parameter int unsigned X_MAX        = 159,
   parameter int unsigned Y_MAX        = 119,
   parameter int unsigned X_INIT       = 80,
   parameter int unsigned Y_INIT       = 60,
   parameter int unsigned POS_W        = 8,
   parameter int unsigned PACKET_BYTES = 3,
   parameter bit          INVERT_Y     = 1'b1,
   parameter int unsigned SHIFT        = 0,
   parameter int unsigned TIMEOUT_CYC  = 50000
) (
   input  logic              clock,
   input  logic              resetn,
   mouse_tracker_if.slave    rx,
   output logic [POS_W-1:0]  o_x_pos,
   output logic [POS_W-1:0]  o_y_pos,
   output logic [2:0]        o_buttons,
   output logic [2:0]        o_click_pulse,
   output logic [3:0]        o_wheel_delta,
   output logic              o_packet_valid,
   output logic              o_sync_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned SUM_W = ((POS_W > 9) ? POS_W : 9) + 2;

   typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2:0]           r_btn;
   logic [1:0]           r_sign;
   logic [1:0]           r_ovf;
   logic [7:0]           r_dx;
   logic [7:0]           r_dy;

   logic [7:0]              w_dy_byte;
   logic signed [8:0]       w_dx_raw, w_dy_raw, w_dx, w_dy;
   logic signed [SUM_W-1:0] w_x_sum, w_y_sum, w_dx_ext, w_dy_ext, w_x_ext, w_y_ext;
   logic [POS_W-1:0]        w_x_new, w_y_new;

   function automatic logic [POS_W-1:0] clamp(input logic signed [SUM_W-1:0] v,
                                              input int unsigned maxv);
      if (v[SUM_W-1])
         return '0;
      else if (v > $signed(SUM_W'(maxv)))
         return POS_W'(maxv);
      else
         return v[POS_W-1:0];
   endfunction

   // dy comes straight off the bus when the packet completes in S_B2
   always_comb begin
      w_dy_byte = (r_state == S_B3) ? r_dy : rx.rx_data;
      w_dx_raw  = r_ovf[0] ? 9'sd0 : $signed({r_sign[0], r_dx});
      w_dy_raw  = r_ovf[1] ? 9'sd0 : $signed({r_sign[1], w_dy_byte});
      w_dx      = w_dx_raw >>> SHIFT;
      w_dy      = w_dy_raw >>> SHIFT;
      w_dx_ext  = SUM_W'(w_dx);
      w_dy_ext  = SUM_W'(w_dy);
      w_x_ext   = $signed(SUM_W'(o_x_pos));
      w_y_ext   = $signed(SUM_W'(o_y_pos));
      w_x_sum   = w_x_ext + w_dx_ext;
      w_y_sum   = INVERT_Y ? (w_y_ext - w_dy_ext) : (w_y_ext + w_dy_ext);
      w_x_new   = clamp(w_x_sum, X_MAX);
      w_y_new   = clamp(w_y_sum, Y_MAX);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state        <= S_B0;
         r_cnt          <= '0;
         r_btn          <= '0;
         r_sign         <= '0;
         r_ovf          <= '0;
         r_dx           <= '0;
         r_dy           <= '0;
         o_x_pos        <= POS_W'(X_INIT);
         o_y_pos        <= POS_W'(Y_INIT);
         o_buttons      <= '0;
         o_click_pulse  <= '0;
         o_wheel_delta  <= '0;
         o_packet_valid <= 1'b0;
         o_sync_err     <= 1'b0;
      end else begin
         o_packet_valid <= 1'b0;
         o_sync_err     <= 1'b0;
         o_click_pulse  <= '0;
         if (rx.rx_valid) begin
            r_cnt <= '0;
            case (r_state)
               S_B0: begin
                  if (rx.rx_data[3]) begin
                     r_btn   <= rx.rx_data[2:0];
                     r_sign  <= rx.rx_data[5:4];
                     r_ovf   <= rx.rx_data[7:6];
                     r_state <= S_B1;
                  end else begin
                     o_sync_err <= 1'b1;
                  end
               end
               S_B1: begin
                  r_dx    <= rx.rx_data;
                  r_state <= S_B2;
               end
               S_B2: begin
                  r_dy <= rx.rx_data;
                  if (PACKET_BYTES == 4) begin
                     r_state <= S_B3;
                  end else begin
                     o_x_pos        <= w_x_new;
                     o_y_pos        <= w_y_new;
                     o_buttons      <= r_btn;
                     o_click_pulse  <= r_btn & ~o_buttons;
                     o_packet_valid <= 1'b1;
                     r_state        <= S_B0;
                  end
               end
               default: begin
                  o_x_pos        <= w_x_new;
                  o_y_pos        <= w_y_new;
                  o_buttons      <= r_btn;
                  o_click_pulse  <= r_btn & ~o_buttons;
                  o_wheel_delta  <= rx.rx_data[3:0];
                  o_packet_valid <= 1'b1;
                  r_state        <= S_B0;
               end
            endcase
         end else if (r_state != S_B0) begin
            // stalled mid-packet: drop the partial packet after TIMEOUT_CYC idle cycles
            if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               r_cnt      <= '0;
               r_state    <= S_B0;
               o_sync_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: a default 3-byte instance and a 4-byte,
// SHIFT=1 instance, with hand-computed cursor expectations.
module tb_mouse_tracker;

   localparam int unsigned TO0 = 100;

   logic clock;
   logic resetn;

   mouse_tracker_if if0 ();
   mouse_tracker_if if1 ();

   logic [7:0] d0_x, d0_y, d1_x, d1_y;
   logic [2:0] d0_btn, d0_clk, d1_btn, d1_clk;
   logic [3:0] d0_whl, d1_whl;
   logic       d0_pv, d0_se, d1_pv, d1_se;

   int n_cmp = 0;
   int n_bad = 0;

   mouse_tracker #(.TIMEOUT_CYC(TO0)) u_dut0 (
      .clock(clock), .resetn(resetn), .rx(if0.slave),
      .o_x_pos(d0_x), .o_y_pos(d0_y), .o_buttons(d0_btn), .o_click_pulse(d0_clk),
      .o_wheel_delta(d0_whl), .o_packet_valid(d0_pv), .o_sync_err(d0_se));

   mouse_tracker #(.PACKET_BYTES(4), .SHIFT(1), .TIMEOUT_CYC(TO0)) u_dut1 (
      .clock(clock), .resetn(resetn), .rx(if1.slave),
      .o_x_pos(d1_x), .o_y_pos(d1_y), .o_buttons(d1_btn), .o_click_pulse(d1_clk),
      .o_wheel_delta(d1_whl), .o_packet_valid(d1_pv), .o_sync_err(d1_se));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int d, input logic [7:0] data, input logic v);
      if (d == 0) begin
         if0.rx_data  = data;
         if0.rx_valid = v;
      end else begin
         if1.rx_data  = data;
         if1.rx_valid = v;
      end
   endtask

   // n bytes back to back, first byte in bits [31:24]; returns on the
   // falling edge after the last byte was accepted
   task automatic send(input int d, input int n, input logic [31:0] bytes);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         drive(d, bytes[31-8*i -: 8], 1'b1);
      end
      @(negedge clock);
      drive(d, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      int k;
      resetn = 1'b0;
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);
      repeat (2) @(negedge clock);
      check_val("rst_x", 32'(d0_x), 32'd80);
      check_val("rst_y", 32'(d0_y), 32'd60);
      check_val("rst_btn", 32'(d0_btn), 32'd0);
      check_val("rst_pv", 32'(d0_pv), 32'd0);
      check_val("rst_se", 32'(d0_se), 32'd0);
      check_val("rst_whl", 32'(d0_whl), 32'd0);
      check_val("rst_x1", 32'(d1_x), 32'd80);
      resetn = 1'b1;

      // basic packet
      send(0, 3, 32'h08050300);
      check_val("p1_x", 32'(d0_x), 32'd85);
      check_val("p1_y", 32'(d0_y), 32'd57);
      check_val("p1_pv", 32'(d0_pv), 32'd1);
      check_val("p1_btn", 32'(d0_btn), 32'd0);
      @(negedge clock);
      check_val("p1_pv_drop", 32'(d0_pv), 32'd0);

      // negative dx, large negative dy clamps to Y_MAX
      do_reset();
      send(0, 3, 32'h38FB0200);
      check_val("p2_x", 32'(d0_x), 32'd75);
      check_val("p2_y", 32'(d0_y), 32'd119);

      // right edge clamp, then full-range negative clamp to 0
      send(0, 3, 32'h08500000);
      check_val("p3a_x", 32'(d0_x), 32'd155);
      send(0, 3, 32'h080A0000);
      check_val("p3b_x", 32'(d0_x), 32'd159);
      send(0, 3, 32'h18000000);
      check_val("p3c_x", 32'(d0_x), 32'd0);
      check_val("p3c_y", 32'(d0_y), 32'd119);

      // misaligned first byte, then button click edges
      send(0, 1, 32'h05000000);
      check_val("p4_se", 32'(d0_se), 32'd1);
      check_val("p4_pv", 32'(d0_pv), 32'd0);
      @(negedge clock);
      check_val("p4_se_drop", 32'(d0_se), 32'd0);
      send(0, 3, 32'h09000000);
      check_val("p4_btn", 32'(d0_btn), 32'd1);
      check_val("p4_click", 32'(d0_clk), 32'd1);
      check_val("p4_x", 32'(d0_x), 32'd0);
      @(negedge clock);
      check_val("p4_click_drop", 32'(d0_clk), 32'd0);
      send(0, 3, 32'h09000000);
      check_val("p4_click_held", 32'(d0_clk), 32'd0);
      check_val("p4_btn_held", 32'(d0_btn), 32'd1);

      // mid-packet timeout
      do_reset();
      send(0, 1, 32'h08000000);
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!d0_se && k < int'(TO0) + 5);
      check_val("to_cycles", 32'(k), 32'(TO0));
      check_val("to_x", 32'(d0_x), 32'd80);
      send(0, 3, 32'h08010000);
      check_val("p5_x", 32'(d0_x), 32'd81);
      check_val("p5_pv", 32'(d0_pv), 32'd1);
      send(0, 3, 32'h487F0000);
      check_val("p5_ovf_x", 32'(d0_x), 32'd81);
      check_val("p5_ovf_pv", 32'(d0_pv), 32'd1);
      check_val("p5_whl", 32'(d0_whl), 32'd0);

      // 4-byte packets with SHIFT=1
      send(1, 4, 32'h0807000F);
      check_val("p6_x", 32'(d1_x), 32'd83);
      check_val("p6_y", 32'(d1_y), 32'd60);
      check_val("p6_whl", 32'(d1_whl), 32'hF);
      check_val("p6_pv", 32'(d1_pv), 32'd1);
      send(1, 4, 32'h18FF0000);
      check_val("p6_neg_round", 32'(d1_x), 32'd82);
      check_val("p6_whl0", 32'(d1_whl), 32'd0);

      // reset mid-packet discards the partial bytes
      send(1, 2, 32'h08070000);
      check_val("p7_pending", 32'(d1_pv), 32'd0);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      check_val("p7_rst_x", 32'(d1_x), 32'd80);
      check_val("p7_rst_y", 32'(d1_y), 32'd60);
      check_val("p7_rst_pv", 32'(d1_pv), 32'd0);
      send(1, 4, 32'h08020000);
      check_val("p7_fresh_x", 32'(d1_x), 32'd81);
      check_val("p7_fresh_pv", 32'(d1_pv), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
